// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, issues in-order word requests, buffers responses in a 2-entry queue.
// Optional same-cycle response bypass to decode is enabled by defining FETCH_BYPASS_EN.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [DATA_WIDTH-1:0] id_pc
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] fpc_q [2];
    logic [DATA_WIDTH-1:0] finst_q [2];
    logic [1:0]            fcnt_q, fcnt_d;
    logic                  frd_q, frd_d;
    logic [DATA_WIDTH-1:0] tag_q [2];
    logic [1:0]            tcnt_q, tcnt_d;
    logic                  trd_q, trd_d;
    logic [1:0]            drop_q, drop_d;

    logic                  rsp_live, byp, fifo_empty;
    logic                  req_fire, fpop, fpush;
    logic [DATA_WIDTH-1:0] tag_head;
    logic [2:0]            occ_buf, occ_mem;

    assign fifo_empty = (fcnt_q == 2'd0);
    assign tag_head   = tag_q[trd_q];
    // A response is "live" only if it is not owed to a flushed request and not killed by a redirect.
    assign rsp_live   = imem_rsp_valid && (drop_q == 2'd0) && !redirect_valid;

`ifdef FETCH_BYPASS_EN
    assign byp = fifo_empty && rsp_live;
`else
    assign byp = 1'b0;
`endif

    assign id_valid = !fifo_empty || byp;
    assign id_pc    = !fifo_empty ? fpc_q[frd_q]   : (byp ? tag_head      : '0);
    assign id_inst  = !fifo_empty ? finst_q[frd_q] : (byp ? imem_rsp_data : NOP);

    assign occ_buf = {1'b0, fcnt_q} + {1'b0, tcnt_q};
    assign occ_mem = {1'b0, tcnt_q} + {1'b0, drop_q};

    assign imem_req_valid = rst_n && !redirect_valid && (occ_buf < 3'd2) && (occ_mem < 3'd2);
    assign imem_req_addr  = pc_q;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign fpop     = id_valid && id_ready && !fifo_empty && !redirect_valid;
    assign fpush    = rsp_live && !(byp && id_ready);

    always_comb begin
        pc_d   = pc_q;
        fcnt_d = fcnt_q;
        tcnt_d = tcnt_q;
        drop_d = drop_q;
        frd_d  = frd_q ^ fpop;
        trd_d  = trd_q ^ rsp_live;
        if (redirect_valid) begin
            pc_d   = redirect_pc & ~DATA_WIDTH'(3);
            fcnt_d = 2'd0;
            tcnt_d = 2'd0;
            // Everything still in flight becomes stale; a response landing now is already accounted for.
            drop_d = 2'(({1'b0, drop_q} + {1'b0, tcnt_q}) - {2'b00, imem_rsp_valid});
        end else begin
            if (req_fire) pc_d = pc_q + DATA_WIDTH'(4);
            fcnt_d = fcnt_q + {1'b0, fpush} - {1'b0, fpop};
            tcnt_d = tcnt_q + {1'b0, req_fire} - {1'b0, rsp_live};
            if (imem_rsp_valid && (drop_q != 2'd0)) drop_d = drop_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q   <= RESET_PC;
            fcnt_q <= 2'd0;
            frd_q  <= 1'b0;
            tcnt_q <= 2'd0;
            trd_q  <= 1'b0;
            drop_q <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                fpc_q[i]   <= '0;
                finst_q[i] <= '0;
                tag_q[i]   <= '0;
            end
        end else begin
            pc_q   <= pc_d;
            fcnt_q <= fcnt_d;
            frd_q  <= frd_d;
            tcnt_q <= tcnt_d;
            trd_q  <= trd_d;
            drop_q <= drop_d;
            // Write slot is head + count; with a full queue that is the slot being popped.
            if (fpush) begin
                fpc_q[frd_q ^ fcnt_q[0]]   <= tag_head;
                finst_q[frd_q ^ fcnt_q[0]] <= imem_rsp_data;
            end
            if (req_fire) tag_q[trd_q ^ tcnt_q[0]] <= pc_q;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_inst;
    logic [31:0] id_pc;

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_inst(id_inst), .id_pc(id_pc)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        ifq[$];
    logic [31:0] tagq[$];
    mreq_t       memq[$];
    int          drop, cyc, lat, lastdue;
    logic [31:0] mpc;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a == 32'h100) ? 32'h0050_0093 : (a ^ 32'h1357_9BDF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ifq.delete(); tagq.delete(); memq.delete();
        drop = 0; mpc = 32'h100; lastdue = cyc;
    endtask

    // Assert reset at the current point, check reset outputs, release one edge later.
    task automatic do_reset();
        redirect_valid = 0; imem_rsp_valid = 0; imem_req_ready = 0; id_ready = 0;
        rst_n = 1'b0;
        model_reset();
        #3;
        chk("rst req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst req_addr", imem_req_addr, 32'h100);
        chk("rst id_valid", 32'(id_valid), 32'd0);
        chk("rst id_inst", id_inst, 32'h13);
        chk("rst id_pc", id_pc, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc++; lastdue = cyc;
    endtask

    // One cycle: drive inputs, compare against the model, then advance model and memory at the edge.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit rdy, input bit idr);
        bit rv, e_req, rlive, byp, e_idv;
        logic [31:0] rd, e_pc, e_inst, t;
        int f, live, due;
        rv = 0; rd = '0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            rv = 1; rd = mdata(memq[0].addr);
        end
        redirect_valid = redir; redirect_pc = rpc; imem_req_ready = rdy; id_ready = idr;
        imem_rsp_valid = rv; imem_rsp_data = rd;
        #3;
        f = ifq.size(); live = tagq.size();
        e_req = !redir && (f + live < 2) && (live + drop < 2);
        rlive = rv && drop == 0 && !redir;
`ifdef FETCH_BYPASS_EN
        byp = (f == 0) && rlive;
`else
        byp = 1'b0;
`endif
        e_idv = (f > 0) || byp;
        e_pc = (f > 0) ? ifq[0].pc : (byp ? tagq[0] : 32'd0);
        e_inst = (f > 0) ? ifq[0].inst : (byp ? rd : 32'h13);
        chk($sformatf("req_valid c%0d", cyc), 32'(imem_req_valid), 32'(e_req));
        chk($sformatf("req_addr c%0d", cyc), imem_req_addr, mpc);
        chk($sformatf("id_valid c%0d", cyc), 32'(id_valid), 32'(e_idv));
        chk($sformatf("id_pc c%0d", cyc), id_pc, e_pc);
        chk($sformatf("id_inst c%0d", cyc), id_inst, e_inst);
        @(posedge clk);
        if (rv) void'(memq.pop_front());
        if (redir) begin
            drop = drop + live - (rv ? 1 : 0);
            ifq.delete(); tagq.delete();
            mpc = {rpc[31:2], 2'b00};
        end else begin
            if (e_idv && idr && f > 0) void'(ifq.pop_front());
            if (rv) begin
                if (drop > 0) drop--;
                else begin
                    t = tagq.pop_front();
                    if (!(byp && idr)) ifq.push_back('{t, rd});
                end
            end
            if (e_req && rdy) begin
                tagq.push_back(mpc);
                due = cyc + lat;
                if (due <= lastdue) due = lastdue + 1;
                lastdue = due;
                memq.push_back('{mpc, due});
                mpc = mpc + 32'd4;
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        bit found;
        cyc = 0; lat = 1;
        #1;
        do_reset();
        // first fetches from 0x100
        repeat (6) step(0, 0, 1, 1);
        // decode stall then release
        repeat (5) step(0, 0, 1, 0);
        repeat (6) step(0, 0, 1, 1);
        // memory back-pressure right after reset: address parks at 0x104
        do_reset();
        step(0, 0, 1, 1);
        repeat (4) step(0, 0, 0, 1);
        repeat (6) step(0, 0, 1, 1);
        // redirect with two requests in flight, latency 3
        lat = 3;
        for (int i = 0; i < 10 && tagq.size() < 2; i++) step(0, 0, 1, 1);
        chk("two_inflight", 32'(tagq.size()), 32'd2);
        step(1, 32'h2002, 1, 1);
        repeat (12) step(0, 0, 1, 1);
        // redirect colliding with a live response and a decode handshake
        lat = 2; found = 0;
        for (int i = 0; i < 40; i++) begin
            if (!found && memq.size() > 0 && memq[0].due <= cyc && drop == 0 && ifq.size() > 0) begin
                step(1, 32'h3000, 1, 1);
                found = 1;
            end else step(0, 0, 1, (i % 3) != 0);
        end
        chk("collision_seen", 32'(found), 32'd1);
        // PC wrap
        lat = 1;
        step(1, 32'hFFFF_FFFC, 1, 1);
        repeat (8) step(0, 0, 1, 1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(1, 4);
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 2) != 0);
        end
        // mid-operation reset
        do_reset();
        for (int i = 0; i < 20; i++)
            step(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
